ultra_wide_bus_serializer: RTL and testbench
============================================

Name: ultra_wide_bus_serializer

Overview:
- Consumer end of the 1024-bit output bus (`ext_out_ultra_wide`).
- Accepts one wide frame per valid/ready handshake and emits it as a stream of narrow words with valid/ready, last and word index.
- Sits between the IP's wide output and narrow downstream logic (FIFO or link), all in the 100 MHz main domain.
- Supports short frames via a per-frame word count, and back-to-back frames with no bubble.

Parameters:
- WIDE_W, 1024: wide input bus width; must be an integer multiple of WORD_W.
- WORD_W, 32: output word width.
- NUM_WORDS, WIDE_W/WORD_W (32): words per full frame (derived, not overridable).
- IDX_W, clog2(NUM_WORDS) (5): index width (derived).
- MSB_FIRST, 0: 0 = word 0 is in_data[WORD_W-1:0]; 1 = word 0 is in_data[WIDE_W-1:WIDE_W-WORD_W].

Ports:
- main_clk_100mhz  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  wide frame available.
- in_ready  output  1  frame accepted when in_valid & in_ready.
- in_data  input  WIDE_W  wide frame.
- in_words  input  IDX_W+1  words to send, 1..NUM_WORDS; 0 and values > NUM_WORDS mean NUM_WORDS.
- out_valid  output  1  word valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  WORD_W  current word.
- out_index  output  IDX_W  position of the current word in its frame, starting at 0.
- out_last  output  1  current word is the final word of the frame.
- busy  output  1  a frame is held (SEND state).
- frame_count  output  16  completed frames; wraps 0xFFFF->0.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, frame_count=0.
  - in_ready=0 while reset_n=0 and for the first rising edge after release; it is driven by a registered init flag.
- States:
  - IDLE: out_valid=0, in_ready=1 (after init).
  - SEND: out_valid=1, busy=1.
- IDLE->SEND: on the edge with in_valid & in_ready.
  - The whole in_data is latched into a shadow register, plus the effective length L.
  - On the same edge: out_index=0, out_data=word 0, out_last=(L==1).
  - Latency: the first word is valid the cycle after acceptance.
- In SEND, in_ready = out_valid & out_ready & out_last (combinational), so a new frame is accepted only on the final word's handshake.
- Word handshake (out_valid & out_ready):
  - not last: out_index+1; out_data and out_last are updated for the next word.
  - last with in_valid=1 (back-to-back): the new frame loads, state stays SEND, out_index=0, out_valid stays 1 with no gap.
  - last with in_valid=0: go to IDLE, out_valid=0, out_data retains its last value.
- frame_count increments on every last-word handshake, including back-to-back ones.
- Stall: while out_valid=1 and out_ready=0, out_data, out_index and out_last are held stable. in_data is not sampled.
- in_data changes after acceptance have no effect because the shadow register is used.
- Word selection:
  - MSB_FIRST=0: word i = shadow[i*WORD_W +: WORD_W].
  - MSB_FIRST=1: word i = shadow[WIDE_W-1-i*WORD_W -: WORD_W].
- Length edge cases: L=1 gives a single word with out_last=1. L=NUM_WORDS ends at out_index=NUM_WORDS-1 with no index overflow.
- Reset asserted mid-frame: the frame is aborted immediately and out_valid drops asynchronously. The frame is not resumed and frame_count is not incremented.
- out_ready asserted while out_valid=0 is ignored.

Test Plan:
1. Full frame, MSB_FIRST=0: in_data word i = 0xA5000000+i, in_words=0, out_ready=1 -> 32 words 0xA5000000..0xA500001F, out_index 0..31, out_last only on index 31, frame_count=1, then IDLE.
2. Short frame plus stall: in_words=3, word i = i+1, out_ready low on cycles 2-4 -> words 1,2,3, out_data/out_index held during the stall, out_last on word 3.
3. Back-to-back: frame A (in_words=2) with frame B (in_words=2) presented continuously -> out_valid never deasserts, sequence A0,A1,B0,B1, frame_count=2, in_ready pulses exactly on the A1 handshake.
4. MSB_FIRST=1, in_data=1024'h0123...EF (in_words=1) -> single word equal to in_data[1023:992], out_last=1.
5. Reset mid-frame: deassert reset_n at out_index=5 -> out_valid=0 immediately; after release in_ready=0 for one edge then 1; frame_count=0; the next frame starts at index 0.
6. frame_count wrap: preload 0xFFFF frames (or force the counter) and complete one more frame -> frame_count=0x0000.

Source files
------------

// File: rtl/ultra_wide_bus_serializer.sv
// Wide-to-narrow frame serializer: latches one WIDE_W frame per handshake and
// streams it out as WORD_W words with index/last, supporting short and back-to-back frames.
module ultra_wide_bus_serializer #(
  parameter int WIDE_W    = 1024,
  parameter int WORD_W    = 32,
  parameter bit MSB_FIRST = 1'b0,
  localparam int NUM_WORDS = WIDE_W / WORD_W,
  localparam int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic              main_clk_100mhz,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDE_W-1:0] in_data,
  input  logic [IDX_W:0]    in_words,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       frame_count,
  output logic              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // valid never waits on ready, and out_* are held stable while out_valid & !out_ready.

  localparam logic [IDX_W:0] FULL_LEN = (IDX_W+1)'(NUM_WORDS);
  localparam logic [IDX_W:0] ONE_LEN  = (IDX_W+1)'(1);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                init_done;
  logic [WIDE_W-1:0]   shadow;
  logic [IDX_W:0]      len_q;
  logic [IDX_W:0]      eff_len;
  logic [IDX_W:0]      next_idx;
  logic                accept;
  logic                word_hs;

  function automatic logic [WORD_W-1:0] pick_word(input logic [WIDE_W-1:0] d,
                                                  input logic [IDX_W:0]    i);
    int lsb;
    if (MSB_FIRST) lsb = WIDE_W - WORD_W * (int'(i) + 1);
    else           lsb = WORD_W * int'(i);
    return d[lsb +: WORD_W];
  endfunction

  // Zero or oversize word counts mean a full frame.
  always_comb begin
    eff_len = in_words;
    if (in_words == '0 || in_words > FULL_LEN) eff_len = FULL_LEN;
  end

  always_ff @(posedge main_clk_100mhz or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = init_done;
        if (in_valid && init_done) state_d = S_SEND;
      end
      S_SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        // Next frame is only taken on the final word's handshake, so there is no bubble.
        in_ready  = out_ready & out_last;
        if (out_ready && out_last && !in_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign word_hs   = out_valid & out_ready;
  assign next_idx  = {1'b0, out_index} + ONE_LEN;
  assign dbg_state = state_q;

  always_ff @(posedge main_clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      init_done   <= 1'b0;
      shadow      <= '0;
      len_q       <= '0;
      out_index   <= '0;
      out_data    <= '0;
      out_last    <= 1'b0;
      frame_count <= '0;
    end else begin
      init_done <= 1'b1;
      if (word_hs && out_last) frame_count <= frame_count + 16'd1;
      if (accept) begin
        shadow    <= in_data;
        len_q     <= eff_len;
        out_index <= '0;
        out_data  <= pick_word(in_data, '0);
        out_last  <= (eff_len == ONE_LEN);
      end else if (word_hs) begin
        if (out_last) begin
          // Frame done with nothing queued: data and index are left as they were.
          out_last <= 1'b0;
        end else begin
          out_index <= next_idx[IDX_W-1:0];
          out_data  <= pick_word(shadow, next_idx);
          out_last  <= ((next_idx + ONE_LEN) == len_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_ultra_wide_bus_serializer.sv
// Self-checking bench for ultra_wide_bus_serializer: LSB-first instance for most scenarios,
// a second MSB-first instance for word ordering.
module tb_ultra_wide_bus_serializer;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;

  logic          in_valid = 1'b0, in_ready;
  logic [1023:0] in_data = '0;
  logic [5:0]    in_words = '0;
  logic          out_valid, out_ready = 1'b0, out_last, busy, dbg_state;
  logic [31:0]   out_data;
  logic [4:0]    out_index;
  logic [15:0]   frame_count;

  logic          in_valid_m = 1'b0, in_ready_m;
  logic [1023:0] in_data_m = '0;
  logic [5:0]    in_words_m = '0;
  logic          out_valid_m, out_ready_m = 1'b0, out_last_m, busy_m, dbg_state_m;
  logic [31:0]   out_data_m;
  logic [4:0]    out_index_m;
  logic [15:0]   frame_count_m;

  logic [37:0]   exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  logic [15:0]   exp_fc = '0;

  always #5 clk = ~clk;

  ultra_wide_bus_serializer #(.MSB_FIRST(1'b0)) dut (
    .main_clk_100mhz(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_words(in_words),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy),
    .frame_count(frame_count), .dbg_state(dbg_state)
  );

  ultra_wide_bus_serializer #(.MSB_FIRST(1'b1)) dut_m (
    .main_clk_100mhz(clk), .reset_n(reset_n),
    .in_valid(in_valid_m), .in_ready(in_ready_m), .in_data(in_data_m), .in_words(in_words_m),
    .out_valid(out_valid_m), .out_ready(out_ready_m), .out_data(out_data_m),
    .out_index(out_index_m), .out_last(out_last_m), .busy(busy_m),
    .frame_count(frame_count_m), .dbg_state(dbg_state_m)
  );

  // Model of the LSB-first instance: pushes {last, index, word} for each expected word.
  task automatic push_frame(input logic [1023:0] d, input logic [5:0] w);
    int len;
    len = (w == 6'd0 || w > 6'd32) ? 32 : int'(w);
    for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), 5'(i), d[i*32 +: 32]});
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready, busy, out_last} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {out_valid, in_ready, busy, out_last});
    end
    n_checks++;
    if ({out_data, out_index, frame_count} !== '0) begin
      n_fail++; $display("FAIL reset_regs: data=%h idx=%0d fc=%0d want 0", out_data, out_index, frame_count);
    end
    reset_n = 1'b1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL init_ready_low: got %b want 0", in_ready); end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL init_ready_high: got %b want 1", in_ready); end
  endtask

  task automatic test_full_frame();
    logic [1023:0] d;
    logic [37:0]   e;
    bit            acc;
    int            cyc;
    for (int i = 0; i < 32; i++) d[i*32 +: 32] = 32'hA500_0000 + i;
    push_frame(d, 6'd0);
    out_ready = 1'b1; in_data = d; in_words = 6'd0; in_valid = 1'b1;
    acc = 0;
    for (cyc = 0; cyc < 20 && !acc; cyc++) begin
      if (in_ready) acc = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++;
    if (!acc) begin n_fail++; $display("FAIL full_accept: in_ready never 1 want 1"); end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({out_last, out_index, out_data} !== e) begin
          n_fail++; $display("FAIL full_word: got %h want %h", {out_last, out_index, out_data}, e);
        end
      end
      @(negedge clk); cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_timeout: %0d words left want 0", exp_q.size()); exp_q.delete(); end
    exp_fc = exp_fc + 16'd1;
    n_checks++;
    if (out_valid !== 1'b0 || frame_count !== exp_fc) begin
      n_fail++; $display("FAIL full_end: valid=%b fc=%0d want 0/%0d", out_valid, frame_count, exp_fc);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || frame_count !== exp_fc || out_data !== 32'hA500_001F) begin
      n_fail++; $display("FAIL idle_ready_ignored: valid=%b fc=%0d data=%h want 0/%0d/a500001f",
                         out_valid, frame_count, out_data, exp_fc);
    end
  endtask

  task automatic test_short_stall();
    logic [1023:0] d;
    logic [37:0]   e;
    bit            acc;
    int            cyc;
    for (int i = 0; i < 32; i++) d[i*32 +: 32] = 32'(i + 1);
    push_frame(d, 6'd3);
    out_ready = 1'b1; in_data = d; in_words = 6'd3; in_valid = 1'b1;
    acc = 0;
    for (cyc = 0; cyc < 20 && !acc; cyc++) begin
      if (in_ready) acc = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data = '1;
    n_checks++;
    if (!acc) begin n_fail++; $display("FAIL short_accept: in_ready never 1 want 1"); end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 50) begin
      out_ready = !(cyc >= 2 && cyc <= 4);
      #1;
      if (out_valid && !out_ready) begin
        n_checks++;
        if ({out_last, out_index, out_data} !== exp_q[0] || in_ready !== 1'b0) begin
          n_fail++; $display("FAIL stall_hold: got %h rdy=%b want %h rdy=0",
                             {out_last, out_index, out_data}, in_ready, exp_q[0]);
        end
      end else if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({out_last, out_index, out_data} !== e) begin
          n_fail++; $display("FAIL short_word: got %h want %h", {out_last, out_index, out_data}, e);
        end
      end
      @(negedge clk); cyc++;
    end
    out_ready = 1'b1;
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL short_timeout: %0d words left want 0", exp_q.size()); exp_q.delete(); end
    exp_fc = exp_fc + 16'd1;
    n_checks++;
    if (out_valid !== 1'b0 || frame_count !== exp_fc) begin
      n_fail++; $display("FAIL short_end: valid=%b fc=%0d want 0/%0d", out_valid, frame_count, exp_fc);
    end
  endtask

  task automatic test_back_to_back();
    logic [1023:0] da, db;
    logic [37:0]   e;
    bit            acc, b_taken;
    int            cyc, pulses;
    for (int i = 0; i < 32; i++) begin
      da[i*32 +: 32] = 32'hB000_0000 + i;
      db[i*32 +: 32] = 32'hC000_0000 + i;
    end
    push_frame(da, 6'd2);
    push_frame(db, 6'd2);
    out_ready = 1'b1; in_data = da; in_words = 6'd2; in_valid = 1'b1;
    acc = 0;
    for (cyc = 0; cyc < 20 && !acc; cyc++) begin
      if (in_ready) acc = 1;
      @(negedge clk);
    end
    in_data = db;
    n_checks++;
    if (!acc) begin n_fail++; $display("FAIL b2b_accept: in_ready never 1 want 1"); end
    cyc = 0; pulses = 0; b_taken = 0;
    while (exp_q.size() > 0 && cyc < 50) begin
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_gap: out_valid=%b want 1", out_valid); end
      if (in_valid && in_ready) begin
        pulses++; b_taken = 1;
        n_checks++;
        if (exp_q.size() != 3 || out_index !== 5'd1 || out_last !== 1'b1) begin
          n_fail++; $display("FAIL b2b_pulse_pos: pending=%0d idx=%0d last=%b want 3/1/1",
                             exp_q.size(), out_index, out_last);
        end
      end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({out_last, out_index, out_data} !== e) begin
          n_fail++; $display("FAIL b2b_word: got %h want %h", {out_last, out_index, out_data}, e);
        end
      end
      @(negedge clk); cyc++;
      if (b_taken) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    n_checks++;
    if (exp_q.size() != 0 || pulses != 1) begin
      n_fail++; $display("FAIL b2b_pulses: left=%0d pulses=%0d want 0/1", exp_q.size(), pulses); exp_q.delete();
    end
    exp_fc = exp_fc + 16'd2;
    n_checks++;
    if (out_valid !== 1'b0 || frame_count !== exp_fc) begin
      n_fail++; $display("FAIL b2b_end: valid=%b fc=%0d want 0/%0d", out_valid, frame_count, exp_fc);
    end
  endtask

  task automatic test_msb_first();
    logic [1023:0] d2;
    logic [37:0]   mq[$];
    logic [37:0]   e;
    bit            acc;
    int            cyc;
    for (int f = 0; f < 2; f++) begin
      if (f == 0) begin
        in_data_m = {16{64'h0123_4567_89AB_CDEF}};
        in_words_m = 6'd1;
        mq.push_back({1'b1, 5'd0, 32'h0123_4567});
      end else begin
        for (int i = 0; i < 32; i++) d2[1023 - i*32 -: 32] = 32'hD000_0000 + i;
        in_data_m = d2;
        in_words_m = 6'd3;
        for (int i = 0; i < 3; i++) mq.push_back({(i == 2), 5'(i), 32'hD000_0000 + 32'(i)});
      end
      out_ready_m = 1'b1; in_valid_m = 1'b1;
      acc = 0;
      for (cyc = 0; cyc < 20 && !acc; cyc++) begin
        if (in_ready_m) acc = 1;
        @(negedge clk);
      end
      in_valid_m = 1'b0;
      n_checks++;
      if (!acc) begin n_fail++; $display("FAIL msb_accept: in_ready never 1 want 1"); end
      cyc = 0;
      while (mq.size() > 0 && cyc < 50) begin
        if (out_valid_m && out_ready_m) begin
          e = mq.pop_front();
          n_checks++;
          if ({out_last_m, out_index_m, out_data_m} !== e) begin
            n_fail++; $display("FAIL msb_word: got %h want %h", {out_last_m, out_index_m, out_data_m}, e);
          end
        end
        @(negedge clk); cyc++;
      end
      n_checks++;
      if (mq.size() != 0 || out_valid_m !== 1'b0) begin
        n_fail++; $display("FAIL msb_end: left=%0d valid=%b want 0/0", mq.size(), out_valid_m); mq.delete();
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [1023:0] d;
    logic [37:0]   e;
    bit            acc, found;
    int            cyc;
    for (int i = 0; i < 32; i++) d[i*32 +: 32] = 32'hE000_0000 + i;
    out_ready = 1'b1; in_data = d; in_words = 6'd0; in_valid = 1'b1;
    acc = 0;
    for (cyc = 0; cyc < 20 && !acc; cyc++) begin
      if (in_ready) acc = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    found = 0;
    for (cyc = 0; cyc < 40 && !found; cyc++) begin
      if (out_valid && out_index == 5'd5) found = 1;
      else @(negedge clk);
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL mid_reach5: index 5 not seen want seen"); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_async_drop: valid=%b busy=%b rdy=%b want 0/0/0", out_valid, busy, in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_fc = '0;
    n_checks++;
    if (in_ready !== 1'b0 || frame_count !== 16'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_release: rdy=%b fc=%0d valid=%b want 0/0/0", in_ready, frame_count, out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_ready_back: rdy=%b valid=%b want 1/0", in_ready, out_valid);
    end
    for (int i = 0; i < 32; i++) d[i*32 +: 32] = 32'hF000_0000 + i;
    push_frame(d, 6'd2);
    in_data = d; in_words = 6'd2; in_valid = 1'b1;
    acc = 0;
    for (cyc = 0; cyc < 20 && !acc; cyc++) begin
      if (in_ready) acc = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 50) begin
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({out_last, out_index, out_data} !== e) begin
          n_fail++; $display("FAIL mid_next_word: got %h want %h", {out_last, out_index, out_data}, e);
        end
      end
      @(negedge clk); cyc++;
    end
    exp_fc = exp_fc + 16'd1;
    n_checks++;
    if (exp_q.size() != 0 || frame_count !== exp_fc) begin
      n_fail++; $display("FAIL mid_next_end: left=%0d fc=%0d want 0/%0d", exp_q.size(), frame_count, exp_fc);
      exp_q.delete();
    end
  endtask

  task automatic test_count_wrap();
    int cyc;
    out_ready = 1'b1; in_words = 6'd1; in_data = {32{32'h5A5A_0001}}; in_valid = 1'b1;
    cyc = 0;
    while (frame_count !== 16'hFFFF && cyc < 70000) begin
      @(negedge clk); cyc++;
    end
    n_checks++;
    if (frame_count !== 16'hFFFF || out_valid !== 1'b1 || out_last !== 1'b1) begin
      n_fail++; $display("FAIL wrap_reach: fc=%h valid=%b last=%b want ffff/1/1", frame_count, out_valid, out_last);
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (frame_count !== 16'h0000 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL wrap_zero: fc=%h valid=%b want 0000/0", frame_count, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_stall();
    test_back_to_back();
    test_msb_first();
    test_reset_mid_frame();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
